// File: rtl/epp_pkg.sv
// Shared EPP definitions: command kinds, gpu register map, host FSM states.
// Imported by epp_host and its bench.
package epp_pkg;

  localparam logic [1:0] EPP_KIND_AWR = 2'd0;
  localparam logic [1:0] EPP_KIND_ARD = 2'd1;
  localparam logic [1:0] EPP_KIND_DWR = 2'd2;
  localparam logic [1:0] EPP_KIND_DRD = 2'd3;

  localparam logic [3:0] EPP_REG_X1_L    = 4'd0;
  localparam logic [3:0] EPP_REG_X1_H    = 4'd1;
  localparam logic [3:0] EPP_REG_Y1_L    = 4'd2;
  localparam logic [3:0] EPP_REG_Y1_H    = 4'd3;
  localparam logic [3:0] EPP_REG_X2_L    = 4'd4;
  localparam logic [3:0] EPP_REG_X2_H    = 4'd5;
  localparam logic [3:0] EPP_REG_Y2_L    = 4'd6;
  localparam logic [3:0] EPP_REG_Y2_H    = 4'd7;
  localparam logic [3:0] EPP_REG_COLOR_L = 4'd8;
  localparam logic [3:0] EPP_REG_COLOR_H = 4'd9;
  localparam logic [3:0] EPP_REG_OP      = 4'd10;
  localparam logic [3:0] EPP_REG_FIFO    = 4'd11;
  localparam logic [3:0] EPP_REG_PAGE    = 4'd12;
  localparam logic [3:0] EPP_REG_IRQ_EN  = 4'd13;
  localparam logic [3:0] EPP_REG_IRQ     = 4'd14;
  localparam logic [3:0] EPP_REG_STATUS  = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    RELEASE
  } epp_state_t;

  function automatic logic kind_is_read(input logic [1:0] k);
    return k[0];
  endfunction

endpackage

// File: rtl/epp_sync.sv
// Two-flop synchronizer for the asynchronous EppWait input.
// Ports: uclk, rst (async, active-high), d (async in), q (synced, resets to 0).
module epp_sync (
  input  logic uclk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge uclk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/epp_host.sv
// EPP initiator: turns single-beat commands into EPP addr/data read/write
// cycles. Ports: uclk/rst, cmd_* request, rsp_* result, busy, Epp* bus.
// Optional EPP_TIMEOUT_EN macro adds a per-phase wait timeout (rsp_err).
module epp_host
  import epp_pkg::*;
#(
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       uclk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_kind,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       busy,
  inout  wire  [7:0] EppDB,
  output logic       EppAstb,
  output logic       EppDstb,
  output logic       EppWR,
  input  logic       EppWait
);

  localparam int SW =
    (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam logic [SW-1:0] SETUP_LAST =
    SW'(SETUP_CYCLES - 1);

  epp_state_t    state;
  logic [1:0]    kind;
  logic [7:0]    db_out;
  logic          db_oe;
  logic [SW-1:0] setup_cnt;
  logic          wait_s;
  logic          tmo_hit;

  epp_sync u_sync (
    .uclk (uclk),
    .rst  (rst),
    .d    (EppWait),
    .q    (wait_s)
  );

  assign EppDB     = db_oe ? db_out : 8'bz;
  // busy lingers through the rsp_valid cycle, delaying the next accept
  assign cmd_ready = (state == IDLE) && !busy;

`ifdef EPP_TIMEOUT_EN
  logic [9:0] tmo_cnt;
  logic       err_q;

  assign tmo_hit = (tmo_cnt == 10'(TIMEOUT_CYCLES - 1));
  assign rsp_err = err_q;

  always_ff @(posedge uclk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      // cleared on entry to STROBE (from SETUP) and RELEASE (on ack)
      if (state == SETUP || (state == STROBE && wait_s))
        tmo_cnt <= '0;
      else if (state == STROBE || state == RELEASE)
        tmo_cnt <= tmo_cnt + 10'd1;
      if (tmo_hit &&
          ((state == STROBE && !wait_s) ||
           (state == RELEASE && wait_s)))
        err_q <= 1'b1;
      else if (state == RELEASE && !wait_s)
        err_q <= 1'b0;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
  assign tmo_hit    = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  always_ff @(posedge uclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      kind      <= '0;
      db_out    <= '0;
      db_oe     <= 1'b0;
      setup_cnt <= '0;
      EppAstb   <= 1'b1;
      EppDstb   <= 1'b1;
      EppWR     <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (busy) begin
            busy <= 1'b0;
          end else if (cmd_valid) begin
            kind      <= cmd_kind;
            db_out    <= cmd_wdata;
            db_oe     <= !kind_is_read(cmd_kind);
            EppWR     <= kind_is_read(cmd_kind);
            setup_cnt <= '0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (setup_cnt == SETUP_LAST) begin
            EppAstb <= kind[1];
            EppDstb <= !kind[1];
            state   <= STROBE;
          end else begin
            setup_cnt <= setup_cnt + 1'b1;
          end
        end
        STROBE: begin
          // a stale ack already high here is taken as the ack
          if (wait_s) begin
            if (kind_is_read(kind))
              rsp_rdata <= EppDB;
            EppAstb <= 1'b1;
            EppDstb <= 1'b1;
            state   <= RELEASE;
          end else if (tmo_hit) begin
            EppAstb   <= 1'b1;
            EppDstb   <= 1'b1;
            db_oe     <= 1'b0;
            EppWR     <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        RELEASE: begin
          if (!wait_s || tmo_hit) begin
            db_oe     <= 1'b0;
            EppWR     <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
